// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared register map, CTRL field positions and hex glyph table
package seven_seg_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_BUTTON = 4'd1;
  localparam logic [3:0] ADDR_EDGE   = 4'd2;
  localparam logic [3:0] ADDR_BLINK  = 4'd3;
  localparam logic [3:0] ADDR_DIGIT0 = 4'd4;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_BRIGHT_LSB = 8;

  localparam logic [7:0] BRIGHT_RESET = 8'hFF;

  // Segment a is bit 0 through segment g at bit 6.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    seg = 7'h00;
    case (value)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser plus hold counter for one active-low button
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample matching the accepted level counts as a bounce and restarts the hold.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - Avalon-MM multiplexed seven-segment display with PWM, blink and buttons
// Define SEVEN_SEG_HEX_DECODE_EN to treat DIGIT[i] as hex value plus dp instead of raw segments.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 6,
  parameter int NUM_BUTTONS     = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [3:0]             avs_address,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  output logic [31:0]            avs_readdata,
  input  logic [NUM_BUTTONS-1:0] button_n,
  output logic [NUM_BUTTONS-1:0] led_button,
  output logic [NUM_DIGITS-1:0]  sel_dig_n,
  output logic [7:0]             sel_seg,
  output logic                   irq
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
`ifdef SEVEN_SEG_HEX_DECODE_EN
  localparam logic [7:0] DIGIT_MASK = 8'h8F;
`else
  localparam logic [7:0] DIGIT_MASK = 8'hFF;
`endif

  logic                   ctrl_en;
  logic                   ctrl_irq_en;
  logic [7:0]             bright;
  logic [NUM_DIGITS-1:0]  blink_mask;
  logic [NUM_BUTTONS-1:0] edge_flags;
  logic [NUM_BUTTONS-1:0] edge_clr;
  logic [NUM_BUTTONS-1:0] accepted;
  logic [NUM_BUTTONS-1:0] pressed;
  logic [NUM_BUTTONS-1:0] pressed_q;
  logic [7:0]             digit [NUM_DIGITS];
  logic [SCAN_W-1:0]      dwell;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             pwm_cnt;
  logic [BLINK_W-1:0]     blink_cnt;
  logic                   blink_phase;
  logic [31:0]            rd_data;
  logic [7:0]             cur_digit;
  logic                   cur_blink;
  logic                   lit;
  logic                   unused_wdata;

  assign unused_wdata = ^avs_writedata[31:16];

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (button_n[b]),
      .level   (accepted[b])
    );
  end

  assign pressed    = ~accepted;
  assign led_button = pressed;
  assign edge_clr   = (avs_write && avs_address == ADDR_EDGE) ?
                      avs_writedata[NUM_BUTTONS-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      bright      <= BRIGHT_RESET;
      blink_mask  <= '0;
      edge_flags  <= '0;
      pressed_q   <= '0;
      irq         <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
    end else begin
      pressed_q  <= pressed;
      // The set term is OR-ed in last so a new press beats a same-cycle clear.
      edge_flags <= (edge_flags & ~edge_clr) | (pressed & ~pressed_q);
      irq        <= ctrl_irq_en & (|edge_flags);
      if (avs_write) begin
        if (avs_address == ADDR_CTRL) begin
          ctrl_en     <= avs_writedata[CTRL_EN_BIT];
          ctrl_irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
          bright      <= avs_writedata[CTRL_BRIGHT_LSB +: 8];
        end
        if (avs_address == ADDR_BLINK) blink_mask <= avs_writedata[NUM_DIGITS-1:0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (avs_address == ADDR_DIGIT0 + 4'(i)) digit[i] <= avs_writedata[7:0] & DIGIT_MASK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell       <= '0;
      idx         <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (dwell == SCAN_W'(SCAN_DIV - 1)) begin
        dwell <= '0;
        idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        dwell <= dwell + SCAN_W'(1);
      end
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (avs_address)
      ADDR_CTRL: begin
        rd_data[CTRL_EN_BIT]             = ctrl_en;
        rd_data[CTRL_IRQ_EN_BIT]         = ctrl_irq_en;
        rd_data[CTRL_BRIGHT_LSB +: 8]    = bright;
      end
      ADDR_BUTTON: rd_data[NUM_BUTTONS-1:0] = pressed;
      ADDR_EDGE:   rd_data[NUM_BUTTONS-1:0] = edge_flags;
      ADDR_BLINK:  rd_data[NUM_DIGITS-1:0]  = blink_mask;
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (avs_address == ADDR_DIGIT0 + 4'(i)) rd_data[7:0] = digit[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_data;
  end

  // Select and segments both derive from the same registers, so they switch together.
  always_comb begin
    cur_digit = '0;
    cur_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = digit[i];
        cur_blink = blink_mask[i];
      end
    end
    lit = ctrl_en && ((bright == 8'hFF) || (pwm_cnt < bright)) && !(cur_blink && blink_phase);
    for (int i = 0; i < NUM_DIGITS; i++) sel_dig_n[i] = !(lit && idx == IDX_W'(i));
  end

`ifdef SEVEN_SEG_HEX_DECODE_EN
  logic unused_digit;
  assign unused_digit = ^cur_digit[6:4];
  assign sel_seg = lit ? {cur_digit[7], hex_to_seg(cur_digit[3:0])} : 8'h00;
`else
  assign sel_seg = lit ? cur_digit : 8'h00;
`endif

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - randomized self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

  localparam int ND = 6;
  localparam int NB = 4;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int BD = 64;
`ifdef SEVEN_SEG_HEX_DECODE_EN
  localparam logic [7:0] DMASK = 8'h8F;
`else
  localparam logic [7:0] DMASK = 8'hFF;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic [NB-1:0] button_n = '1;
  logic [NB-1:0] led_button;
  logic [ND-1:0] sel_dig_n;
  logic [7:0]    sel_seg;
  logic          irq;

  int asserts = 0;
  int failures = 0;
  int cyc;

  bit            m_en;
  bit            m_irq_en;
  int            m_bright;
  logic [ND-1:0] m_blink;
  logic [7:0]    m_digit [ND];
  logic [6:0]    glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .NUM_BUTTONS(NB), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .button_n(button_n), .led_button(led_button), .sel_dig_n(sel_dig_n),
    .sel_seg(sel_seg), .irq(irq)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; every free-running counter is a function of this.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [7:0] exp_seg_of(input logic [7:0] d);
`ifdef SEVEN_SEG_HEX_DECODE_EN
    return {d[7], glyph[d[3:0]]};
`else
    return d;
`endif
  endfunction

  task automatic model(output logic [ND-1:0] dn, output logic [7:0] seg);
    int idx;
    int pwm;
    bit phase;
    bit on;
    idx   = (cyc / SD) % ND;
    pwm   = cyc % 256;
    phase = ((cyc / BD) % 2) == 1;
    on    = m_en && (m_bright == 255 || pwm < m_bright) && !(m_blink[idx] && phase);
    dn    = '1;
    seg   = '0;
    if (on) begin
      dn[idx] = 1'b0;
      seg     = exp_seg_of(m_digit[idx]);
    end
  endtask

  task automatic reset_shadow();
    m_en = 0; m_irq_en = 0; m_bright = 255; m_blink = '0;
    for (int i = 0; i < ND; i++) m_digit[i] = '0;
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic avs_wr(input logic [3:0] a, input logic [31:0] d);
    int k;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    k = int'(a);
    if (k == 0) begin
      m_en = d[0]; m_irq_en = d[1]; m_bright = int'(d[15:8]);
    end else if (k == 3) begin
      m_blink = d[ND-1:0];
    end else if (k >= 4 && k < 4 + ND) begin
      m_digit[k-4] = d[7:0] & DMASK;
    end
  endtask

  task automatic avs_rd(input logic [3:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic check_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] got;
    avs_rd(a, got);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: read addr %0d got %h, required %h", tag, a, got, exp);
    end
  endtask

  task automatic check_display(input int n, input string tag, output int dut_lit);
    logic [ND-1:0] edn;
    logic [7:0]    eseg;
    dut_lit = 0;
    for (int i = 0; i < n; i++) begin
      model(edn, eseg);
      asserts++;
      if (sel_dig_n !== edn || sel_seg !== eseg) begin
        failures++;
        $display("FAIL %s cyc=%0d: sel_dig_n=%h sel_seg=%h, required sel_dig_n=%h sel_seg=%h",
                 tag, cyc, sel_dig_n, sel_seg, edn, eseg);
      end
      if (sel_dig_n !== '1) dut_lit++;
      @(negedge clk);
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    asserts++;
    if (sel_dig_n !== '1 || sel_seg !== 8'h00 || led_button !== '0 || irq !== 1'b0 ||
        avs_readdata !== 32'h0) begin
      failures++;
      $display("FAIL %s: dig=%h seg=%h led=%h irq=%b rd=%h, required dig=%h seg=00 led=0 irq=0 rd=0",
               tag, sel_dig_n, sel_seg, led_button, irq, avs_readdata, {ND{1'b1}});
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; button_n = '1; avs_read = 0; avs_write = 0; avs_address = '0;
    reset_shadow();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    check_outputs_reset("reset_outputs");
    check_read(4'd0, 32'h0000FF00, "reset_ctrl");
    check_read(4'd1, 32'h0, "reset_button");
    check_read(4'd2, 32'h0, "reset_edge");
    check_read(4'd3, 32'h0, "reset_blink");
    for (int i = 0; i < ND; i++) check_read(4'(4 + i), 32'h0, "reset_digit");
  endtask

  task automatic test_registers();
    logic [31:0] d;
    logic [31:0] held;
    for (int i = 0; i < ND; i++) avs_wr(4'(4 + i), $urandom);
    for (int a = 4 + ND; a < 16; a++) avs_wr(4'(a), $urandom);
    avs_wr(4'd1, 32'hFFFF_FFFF);
    for (int i = 0; i < ND; i++) check_read(4'(4 + i), {24'h0, m_digit[i]}, "digit_readback");
    for (int a = 4 + ND; a < 16; a++) check_read(4'(a), 32'h0, "unused_addr");
    check_read(4'd1, 32'h0, "button_ro");
    d = $urandom;
    avs_wr(4'd0, d);
    check_read(4'd0, {16'h0, d[15:8], 6'h0, d[1:0]}, "ctrl_readback");
    d = $urandom;
    avs_wr(4'd3, d);
    check_read(4'd3, {{(32-ND){1'b0}}, d[ND-1:0]}, "blink_readback");
    held = avs_readdata;
    avs_address = 4'd0;
    repeat (3) @(negedge clk);
    asserts++;
    if (avs_readdata !== {{(32-ND){1'b0}}, d[ND-1:0]} || held !== avs_readdata) begin
      failures++;
      $display("FAIL readdata_hold: got %h, required %h", avs_readdata, {{(32-ND){1'b0}}, d[ND-1:0]});
    end
  endtask

  task automatic test_scan();
    int n;
    avs_wr(4'd3, 32'h0);
    for (int i = 0; i < ND; i++) avs_wr(4'(4 + i), 32'(i + 1));
    avs_wr(4'd0, 32'h0000FF01);
    check_display(2 * ND * SD + 3, "scan_seq", n);
    avs_wr(4'd4, 32'h08);
    for (int i = 1; i < ND; i++) avs_wr(4'(4 + i), $urandom);
    check_display(3 * ND * SD, "scan_random", n);
  endtask

  task automatic test_pwm();
    int levels [4];
    int n;
    int exp;
    levels[0] = 8'h40; levels[1] = 0; levels[2] = $urandom_range(1, 254); levels[3] = 255;
    avs_wr(4'd3, 32'h0);
    foreach (levels[j]) begin
      avs_wr(4'd0, 32'(levels[j] << 8) | 32'h1);
      check_display(256, "pwm_cycle", n);
      exp = (levels[j] == 255) ? 256 : levels[j];
      asserts++;
      if (n != exp) begin
        failures++;
        $display("FAIL pwm_duty brightness=%0d: lit %0d of 256, required %0d", levels[j], n, exp);
      end
    end
  endtask

  task automatic test_blink();
    int n;
    avs_wr(4'd0, 32'h0000FF01);
    avs_wr(4'd3, 32'h01);
    check_display(4 * BD + 7, "blink_digit0", n);
    avs_wr(4'd3, $urandom);
    avs_wr(4'd0, 32'(($urandom_range(1, 255)) << 8) | 32'h1);
    check_display(3 * BD, "blink_random", n);
    avs_wr(4'd3, 32'h0);
  endtask

  task automatic test_disable_midscan();
    int n;
    avs_wr(4'd0, 32'h0000FF01);
    check_display(ND * SD / 2 + 1, "enabled", n);
    avs_wr(4'd0, 32'h0000FF00);
    check_display(2 * ND * SD, "disabled", n);
    avs_wr(4'd0, 32'h0000FF01);
    check_display(2 * ND * SD, "reenabled", n);
  endtask

  task automatic test_buttons();
    int b;
    int len;
    logic [NB-1:0] bm;
    logic [NB-1:0] exp;
    b  = $urandom_range(0, NB - 1);
    bm = NB'(1 << b);
    avs_wr(4'd0, 32'h0000FF01);
    for (int r = 0; r < 4; r++) begin
      len = (r == 0) ? 5 : $urandom_range(1, DB - 1);
      button_n[b] = 1'b0;
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        asserts++;
        if (led_button !== '0) begin
          failures++;
          $display("FAIL bounce_low: led_button=%h, required 0", led_button);
        end
      end
      button_n[b] = 1'b1;
      repeat (3) @(negedge clk);
    end
    button_n[b] = 1'b0;
    for (int j = 1; j <= DB + 2; j++) begin
      @(negedge clk);
      exp = (j == DB + 2) ? bm : '0;
      asserts++;
      if (led_button !== exp) begin
        failures++;
        $display("FAIL press_timing edge %0d: led_button=%h, required %h", j, led_button, exp);
      end
    end
    repeat (2) @(negedge clk);
    check_read(4'd2, 32'(bm), "edge_set");
    check_read(4'd1, 32'(bm), "button_state");
    asserts++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_masked: irq=%b, required 0", irq);
    end
    avs_wr(4'd0, 32'h0000FF03);
    @(negedge clk);
    asserts++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_enabled: irq=%b, required 1", irq);
    end
    button_n[b] = 1'b1;
    repeat (DB + 4) @(negedge clk);
    asserts++;
    if (led_button !== '0 || irq !== 1'b1) begin
      failures++;
      $display("FAIL release: led_button=%h irq=%b, required 0 and 1", led_button, irq);
    end
    // Second press: the clear lands on the exact edge that latches the new press.
    button_n[b] = 1'b0;
    repeat (DB + 2) @(negedge clk);
    avs_wr(4'd2, 32'(bm));
    for (int j = 0; j < 3; j++) begin
      asserts++;
      if (irq !== 1'b1) begin
        failures++;
        $display("FAIL collision_irq: irq=%b, required 1", irq);
      end
      @(negedge clk);
    end
    check_read(4'd2, 32'(bm), "collision_edge");
    avs_wr(4'd2, 32'hF);
    @(negedge clk);
    asserts++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c_irq: irq=%b, required 0", irq);
    end
    check_read(4'd2, 32'h0, "w1c_edge");
    button_n[b] = 1'b1;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int n;
    button_n[0] = 1'b0;
    repeat (DB + 4) @(negedge clk);
    avs_wr(4'd0, 32'h0000FF03);
    for (int i = 0; i < ND; i++) avs_wr(4'(4 + i), 32'hFF);
    check_read(4'd0, 32'h0000FF03, "pre_reset_ctrl");
    #2 reset_n = 1'b0;
    #1 check_outputs_reset("async_reset");
    button_n = '1;
    reset_shadow();
    @(negedge clk);
    reset_n = 1'b1;
    check_read(4'd0, 32'h0000FF00, "post_reset_ctrl");
    check_read(4'd4, 32'h0, "post_reset_digit0");
    check_read(4'd2, 32'h0, "post_reset_edge");
    avs_wr(4'd4, $urandom);
    avs_wr(4'd0, 32'h0000FF01);
    check_display(ND * SD + 5, "post_reset_scan", n);
  endtask

  initial begin
    do_reset();
    test_reset();
    test_registers();
    test_scan();
    test_pwm();
    test_blink();
    test_disable_midscan();
    test_buttons();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
